// File: rtl/m_rv32_pkg.sv
// Shared RV32I definitions: base opcodes and the one-hot format-flag layout
// used by decode, the immediate generator and control decode.
package m_rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Bit positions of each flag inside fmt_t (MSB first).
  localparam int FMT_W       = 7;
  localparam int FMT_I       = 6;
  localparam int FMT_S       = 5;
  localparam int FMT_B       = 4;
  localparam int FMT_U       = 3;
  localparam int FMT_J       = 2;
  localparam int FMT_R       = 1;
  localparam int FMT_ILLEGAL = 0;

  typedef struct packed {
    logic i;
    logic s;
    logic b;
    logic u;
    logic j;
    logic r;
    logic illegal;
  } fmt_t;

endpackage

// File: rtl/m_opcode_decode.sv
// Combinational opcode classifier: ir[6:0] to one-hot format flags.
// Anything outside the RV32I base set, including ir[1:0] != 2'b11, is illegal.
module m_opcode_decode
  import m_rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output fmt_t       fmt
);

  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    fmt = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: fmt.i = 1'b1;
      OP_STORE:                                     fmt.s = 1'b1;
      OP_BRANCH:                                    fmt.b = 1'b1;
      OP_LUI, OP_AUIPC:                             fmt.u = 1'b1;
      OP_JAL:                                       fmt.j = 1'b1;
      OP_OP:                                        fmt.r = 1'b1;
      default:                                      fmt.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/m_decode_buffer.sv
// Decode stage: classifies each accepted instruction and holds it with its
// flags in a two-entry skid buffer (main drives outputs, skid absorbs a stall).
module m_decode_buffer
  import m_rv32_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_ir,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_ir,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                i,
  output logic                s,
  output logic                b,
  output logic                u,
  output logic                j,
  output logic                r,
  output logic                illegal
);

  typedef struct packed {
    logic                valid;
    logic [31:0]         ir;
    logic [PC_WIDTH-1:0] pc;
    fmt_t                fmt;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_entry;
  fmt_t   in_fmt;
  logic   push, pop;

  m_opcode_decode u_opcode_decode (
    .opcode (in_ir[6:0]),
    .fmt    (in_fmt)
  );

  assign new_entry = '{valid: 1'b1, ir: in_ir, pc: in_pc, fmt: in_fmt};

  // Ready comes straight from a flop so out_ready never reaches in_ready.
  assign in_ready = ~skid_q.valid;
  assign push     = in_valid & in_ready;
  assign pop      = main_q.valid & out_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (pop) begin
      if (skid_q.valid) begin
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (push) begin
        main_d = new_entry;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (push) begin
      if (!main_q.valid) main_d = new_entry;
      else               skid_d = new_entry;
    end
  end

  // NOTE: payload is reset along with valid because the reset values of
  // out_ir/out_pc/flags are observable, not just don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_valid = main_q.valid;
  assign out_ir    = main_q.ir;
  assign out_pc    = main_q.pc;
  assign i         = main_q.fmt.i;
  assign s         = main_q.fmt.s;
  assign b         = main_q.fmt.b;
  assign u         = main_q.fmt.u;
  assign j         = main_q.fmt.j;
  assign r         = main_q.fmt.r;
  assign illegal   = main_q.fmt.illegal;

endmodule

// File: tb/tb_m_decode_buffer.sv
// Directed and random self-checking bench for m_decode_buffer.
module tb_m_decode_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_ir, in_pc, out_ir, out_pc;
  logic        i, s, b, u, j, r, illegal;
  logic [6:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] F_I = 7'b1000000, F_S = 7'b0100000, F_B = 7'b0010000,
                         F_U = 7'b0001000, F_J = 7'b0000100, F_R = 7'b0000010,
                         F_ILL = 7'b0000001;

  m_decode_buffer #(.PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .i(i), .s(s), .b(b), .u(u), .j(j), .r(r), .illegal(illegal)
  );

  always #5 clk = ~clk;
  assign flags = {i, s, b, u, j, r, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference classifier from the RV32I opcode map.
  function automatic logic [6:0] ref_flags(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: return F_I;
      7'h23: return F_S;
      7'h63: return F_B;
      7'h37, 7'h17: return F_U;
      7'h6F: return F_J;
      7'h33: return F_R;
      default: return F_ILL;
    endcase
  endfunction

  typedef struct packed { logic [31:0] ir; logic [31:0] pc; } word_t;
  word_t       exp_q[$];
  logic [31:0] fmt_words [6] = '{32'h00500093, 32'h00112623, 32'h00208463,
                                 32'h123450B7, 32'h008000EF, 32'h002081B3};
  logic [6:0]  fmt_flags [6] = '{F_I, F_S, F_B, F_U, F_J, F_R};
  logic [31:0] ill_words [2] = '{32'h00000000, 32'hFFFFFFFF};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ir = '0; in_pc = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_ir",    out_ir, 32'd0);
    check("rst_out_pc",    out_pc, 32'd0);
    check("rst_flags",     32'(flags), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Format decode, streaming one word per cycle
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_ir = fmt_words[k]; in_pc = 32'(k * 4);
      check("fmt_in_ready", 32'(in_ready), 32'd1);
      step();
      check("fmt_out_valid", 32'(out_valid), 32'd1);
      check("fmt_out_ir",    out_ir, fmt_words[k]);
      check("fmt_out_pc",    out_pc, 32'(k * 4));
      check("fmt_flags",     32'(flags), 32'(fmt_flags[k]));
    end

    // Illegal passthrough
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_ir = ill_words[k]; in_pc = 32'h80 + 32'(k * 4);
      step();
      check("ill_out_valid", 32'(out_valid), 32'd1);
      check("ill_out_ir",    out_ir, ill_words[k]);
      check("ill_flags",     32'(flags), 32'(F_ILL));
    end
    in_valid = 1'b0;
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: only two words accepted while stalled
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00000013; in_pc = 32'h0;
    step();
    check("bp_first_ready", 32'(in_ready), 32'd1);
    check("bp_first_pc",    out_pc, 32'h0);
    in_pc = 32'h4;
    step();
    check("bp_ready_drop",  32'(in_ready), 32'd0);
    check("bp_hold_pc",     out_pc, 32'h0);
    in_pc = 32'h8;
    step();
    check("bp_still_full",  32'(in_ready), 32'd0);
    check("bp_stall_valid", 32'(out_valid), 32'd1);
    check("bp_stall_pc",    out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    check("bp_pop1_pc",     out_pc, 32'h4);
    check("bp_ready_rise",  32'(in_ready), 32'd1);
    step();
    check("bp_pop2_pc",     out_pc, 32'h8);
    check("bp_pop2_valid",  32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_empty",       32'(out_valid), 32'd0);

    // Flush with both entries full and a word offered
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h20;
    step();
    in_pc = 32'h24;
    step();
    check("fl_full", 32'(in_ready), 32'd0);
    in_pc = 32'h28; flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready",  32'(in_ready),  32'd1);
    in_pc = 32'h2C; out_ready = 1'b1;
    step();
    check("fl_next_valid", 32'(out_valid), 32'd1);
    check("fl_next_pc",    out_pc, 32'h2C);
    // A push coinciding with flush must be discarded
    in_pc = 32'h30; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_push_drop", 32'(out_valid), 32'd0);
    step();
    check("fl_push_gone", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00C00093; in_pc = 32'h40;
    step();
    in_pc = 32'h44;
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_ir",    out_ir, 32'd0);
    check("arst_out_pc",    out_pc, 32'd0);
    check("arst_flags",     32'(flags), 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0; in_valid = 1'b1; in_ir = 32'h00000013; in_pc = 32'h100; out_ready = 1'b1;
    step();
    check("arst_first_valid", 32'(out_valid), 32'd1);
    check("arst_first_pc",    out_pc, 32'h100);
    in_valid = 1'b0;
    step();
    check("arst_alone", 32'(out_valid), 32'd0);

    // Random handshake against a reference FIFO
    begin
      logic        last_push = 1'b1;
      logic        do_push, do_pop;
      int unsigned seq = 0;
      in_valid = 1'b0;
      for (int c = 0; c < 10000; c++) begin
        check("rnd_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("rnd_ready", 32'(in_ready),  32'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
          check("rnd_ir",    out_ir, exp_q[0].ir);
          check("rnd_pc",    out_pc, exp_q[0].pc);
          check("rnd_flags", 32'(flags), 32'(ref_flags(exp_q[0].ir)));
        end
        out_ready = ($urandom_range(3) != 0);
        if (!in_valid || last_push) begin
          in_valid = ($urandom_range(3) != 0);
          in_ir    = $urandom;
          in_pc    = 32'(seq * 4);
          seq++;
        end
        do_push = in_valid && in_ready;
        do_pop  = out_valid && out_ready;
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{ir: in_ir, pc: in_pc});
        last_push = do_push;
        step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step(); step();
      check("rnd_drained", 32'(out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
